pipe_hazard_ctrl: RTL and testbench

Central scheduler for the five-stage pipeline. It decides each cycle which pipeline registers advance, hold, or take a bubble, using:
- the load-use hazard,
- the taken-branch/jump flush raised by the execute stage,
- instruction- and data-memory stalls,
- halt draining.

It sits beside the decode stage. It owns every write-enable and bubble control on the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, so the execute stage's forwarding always sees a consistent pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline scheduler: load-use bubbles, branch flushes, memory stalls and halt draining.
// Optional hazard statistics counters are compiled in when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] IFID_Instr,
   input  logic        IFID_ValidRt,
   input  logic        IDEX_MemRead,
   input  logic [2:0]  IDEX_DstRegNum,
   input  logic        ex_flush,
   input  logic        imem_stall,
   input  logic        dmem_stall,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_bubble,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        halt_out,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {RUN, LDUSE, DRAIN, HALTED} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
   logic             ld_use;
   logic             halt_id;
   logic             flush_taken;
   logic             unused_instr_bits;

   assign ld_use  = IDEX_MemRead &
                    ((IDEX_DstRegNum == IFID_Instr[10:8]) |
                     (IFID_ValidRt & (IDEX_DstRegNum == IFID_Instr[7:5])));
   assign halt_id = (IFID_Instr[15:11] == 5'b00000);
   assign unused_instr_bits = ^IFID_Instr[4:0];

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      flush_taken   = 1'b0;
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      ifid_flush    = 1'b0;
      idex_en       = 1'b0;
      idex_bubble   = 1'b0;
      exmem_en      = 1'b0;
      memwb_en      = 1'b0;

      case (state)
         RUN, LDUSE: begin
            // A data-memory stall freezes everything, so the pending decision is re-made next cycle.
            if (!dmem_stall) begin
               state_nxt = RUN;
               idex_en   = 1'b1;
               exmem_en  = 1'b1;
               memwb_en  = 1'b1;
               if (ex_flush) begin
                  flush_taken = 1'b1;
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (state == RUN && ld_use) begin
                  idex_bubble = 1'b1;
                  state_nxt   = LDUSE;
               end else if (state == RUN && halt_id) begin
                  ifid_en       = 1'b1;
                  ifid_flush    = 1'b1;
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = DRAIN_LOAD;
               end else if (imem_stall) begin
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
               end
            end
         end
         DRAIN: begin
            // No older branch can still be in flight here, so ex_flush is not consulted.
            if (!dmem_stall) begin
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               idex_en     = 1'b1;
               idex_bubble = 1'b1;
               exmem_en    = 1'b1;
               memwb_en    = 1'b1;
               if (drain_cnt == '0) begin
                  state_nxt = HALTED;
               end else begin
                  drain_cnt_nxt = drain_cnt - 1'b1;
               end
            end
         end
         HALTED: begin
            state_nxt = HALTED;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase

      if (rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_en     = 1'b0;
         idex_bubble = 1'b1;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         flush_taken = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   assign halt_out = (state == HALTED);

`ifdef HAZARD_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_en && state != HALTED) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end
         if (flush_taken) begin
            flush_cnt_q <= sat_inc(flush_cnt_q);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = 16'h0000;
   assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized
// stimulus compared every cycle against a behavioural scheduling model.
module tb_pipe_hazard_ctrl;

   localparam int DRAIN_CYCLES = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] IFID_Instr;
   logic        IFID_ValidRt;
   logic        IDEX_MemRead;
   logic [2:0]  IDEX_DstRegNum;
   logic        ex_flush;
   logic        imem_stall;
   logic        dmem_stall;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
   logic        halt_out;
   logic [15:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model: halted flag, remaining drain cycles (0 = not draining), pending load-use bubble slot.
   bit m_halted;
   int m_drain_left;
   bit m_after_lduse;
   int m_stalls;
   int m_flushes;

   pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clk(clk), .rst(rst), .IFID_Instr(IFID_Instr), .IFID_ValidRt(IFID_ValidRt),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_DstRegNum(IDEX_DstRegNum), .ex_flush(ex_flush),
      .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .halt_out(halt_out),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model at the edge.
   task automatic step(input bit r, input logic [15:0] ins, input bit vrt, input bit mr,
                       input logic [2:0] dst, input bit fl, input bit im, input bit dm);
      logic [6:0] e;   // {pc, ifid, ifid_flush, idex, bubble, exmem, memwb}
      bit ld, hlt, draining, stall_inc, flush_inc;
      int exp_s, exp_f;
      rst = r; IFID_Instr = ins; IFID_ValidRt = vrt; IDEX_MemRead = mr;
      IDEX_DstRegNum = dst; ex_flush = fl; imem_stall = im; dmem_stall = dm;
      #2;
      ld  = mr && ((dst == ins[10:8]) || (vrt && dst == ins[7:5]));
      hlt = (ins[15:11] == 5'd0);
      draining = (m_drain_left > 0);
      if (r)                                   e = 7'b0010100;
      else if (m_halted)                       e = 7'b0000000;
      else if (dm)                             e = 7'b0000000;
      else if (draining)                       e = 7'b0111111;
      else if (fl)                             e = 7'b1111111;
      else if (ld && !m_after_lduse)           e = 7'b0001111;
      else if (hlt && !m_after_lduse)          e = 7'b0111011;
      else if (im)                             e = 7'b0111011;
      else                                     e = 7'b1101011;
`ifdef HAZARD_STATS_EN
      exp_s = m_stalls; exp_f = m_flushes;
`else
      exp_s = 0; exp_f = 0;
`endif
      check_eq("ctrl", {25'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en},
               {25'd0, e});
      check_eq("halt_out", {31'd0, halt_out}, {31'd0, m_halted});
      check_eq("stall_cnt", {16'd0, stall_cnt}, exp_s);
      check_eq("flush_cnt", {16'd0, flush_cnt}, exp_f);
      stall_inc = !r && !m_halted && !e[6];
      flush_inc = !r && !m_halted && !draining && !dm && fl;
      @(posedge clk);
      if (r) begin
         m_halted = 0; m_drain_left = 0; m_after_lduse = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (stall_inc && m_stalls < 65535) m_stalls++;
         if (flush_inc && m_flushes < 65535) m_flushes++;
         if (!m_halted && !dm) begin
            if (draining) begin
               m_drain_left--;
               if (m_drain_left == 0) m_halted = 1;
            end else if (m_after_lduse) begin
               m_after_lduse = 0;
            end else if (!fl) begin
               if (ld) m_after_lduse = 1;
               else if (hlt) m_drain_left = DRAIN_CYCLES;
            end
         end
      end
      #1;
   endtask

   localparam logic [15:0] ADD_R3_R2_R4 = {5'b00001, 3'd2, 3'd4, 5'd3};
   localparam logic [15:0] ADD_R5_R6_R7 = {5'b00001, 3'd6, 3'd7, 5'd5};
   localparam logic [15:0] HALT_INS     = 16'h0000;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, ADD_R5_R6_R7, 1, 0, 3'd1, 0, 0, 0);
   endtask

   // Puts a halt in ID, then counts cycles until halt_out rises; one dmem stall at index stall_at.
   task automatic run_halt(input int stall_at, input int exp_cycles);
      int k;
      bit seen;
      step(1, ADD_R5_R6_R7, 0, 0, 3'd0, 0, 0, 0);
      step(0, HALT_INS, 0, 0, 3'd0, 0, 0, 0);
      k = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (halt_out === 1'b1) begin
            seen = 1;
            break;
         end
         step(0, ADD_R5_R6_R7, 0, 0, 3'd1, 0, 0, (k == stall_at));
         k++;
      end
      check_eq("halt_seen", {31'd0, seen}, 32'd1);
      check_eq("halt_latency", k, exp_cycles);
   endtask

   initial begin
      rst = 1; IFID_Instr = ADD_R5_R6_R7; IFID_ValidRt = 0; IDEX_MemRead = 0;
      IDEX_DstRegNum = 0; ex_flush = 0; imem_stall = 0; dmem_stall = 0;
      m_halted = 0; m_drain_left = 0; m_after_lduse = 0; m_stalls = 0; m_flushes = 0;
      @(posedge clk); #1;
      step(1, ADD_R5_R6_R7, 0, 0, 3'd0, 0, 0, 0);
      idle(2);

      // Load-use: LD r2 in EX, ADD r3,r2,r4 in ID.
      step(0, ADD_R3_R2_R4, 1, 1, 3'd2, 0, 0, 0);
      step(0, ADD_R3_R2_R4, 1, 0, 3'd0, 0, 0, 0);
      idle(1);
      // Load-use through rt only.
      step(0, ADD_R3_R2_R4, 1, 1, 3'd4, 0, 0, 0);
      step(0, ADD_R3_R2_R4, 1, 0, 3'd0, 0, 0, 0);
      // Branch flush.
      step(0, ADD_R5_R6_R7, 1, 0, 3'd0, 1, 0, 0);
      idle(1);
      // dmem stall held 4 cycles over a load-use, then the bubble.
      for (int i = 0; i < 4; i++) step(0, ADD_R3_R2_R4, 1, 1, 3'd2, 0, 0, 1);
      step(0, ADD_R3_R2_R4, 1, 1, 3'd2, 0, 0, 0);
      step(0, ADD_R3_R2_R4, 1, 0, 3'd0, 0, 0, 0);
      // Flush beats load-use; imem stall.
      step(0, ADD_R3_R2_R4, 1, 1, 3'd2, 1, 0, 0);
      step(0, ADD_R5_R6_R7, 1, 0, 3'd0, 0, 1, 0);
      // Flush beats halt.
      step(0, HALT_INS, 0, 0, 3'd0, 1, 0, 0);
      idle(5);

      run_halt(-1, DRAIN_CYCLES);
      idle(2);
      step(1, ADD_R5_R6_R7, 0, 0, 3'd0, 0, 0, 0);
      idle(2);
      run_halt(1, DRAIN_CYCLES + 1);
      // Reset mid-drain.
      step(1, ADD_R5_R6_R7, 0, 0, 3'd0, 0, 0, 0);
      step(0, HALT_INS, 0, 0, 3'd0, 0, 0, 0);
      step(0, ADD_R5_R6_R7, 0, 0, 3'd0, 0, 0, 0);
      step(1, ADD_R5_R6_R7, 0, 0, 3'd0, 0, 0, 0);
      idle(3);

      for (int i = 0; i < 4000; i++) begin
         logic [15:0] ins;
         bit r;
         ins = 16'($urandom);
         if ($urandom_range(0, 24) == 0) ins[15:11] = 5'd0;
         else if (ins[15:11] == 5'd0) ins[15:11] = 5'd1;
         r = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
         step(r, ins, 1'($urandom), ($urandom_range(0, 2) == 0), 3'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 5) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
